async_fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of an async_fifo (wr_clk domain) among NUM_REQ requesters.

---
 rtl/async_fifo_wr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : async_fifo_wr_arbiter
//  Purpose  : Shares the single write port of an async FIFO (wr_clk domain)
//             among NUM_REQ requesters. Round-robin arbitration with bounded
//             bursts: a granted requester keeps the port for at most
//             MAX_BURST beats, then the next requester in order gets a turn.
//             Only the FIFO full flag is observed; no read-domain logic.
//  Ports    : wr_clk        write-domain clock
//             wr_rst        asynchronous reset, active low
//             req_valid     per-requester beat valid            [NUM_REQ]
//             req_data      requester i data at [i*WIDTH +: WIDTH]
//             req_ready     per-requester beat accepted          [NUM_REQ]
//             fifo_full     FIFO full flag (wr_clk domain)
//             fifo_wr_en    FIFO write enable
//             fifo_data_in  FIFO write data                      [WIDTH]
//             grant_valid   a burst is currently granted
//             grant_id      granted requester index              [GW]
//  Revision : 1.0 - initial release
// ============================================================================
module async_fifo_wr_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int c_GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic                       grant_valid,
    output logic [c_GW-1:0]            grant_id
);

    // Beat counter only needs to reach MAX_BURST-1 before the burst ends.
    localparam int              c_BW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_BW-1:0] c_LAST = c_BW'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_GW-1:0]    r_rr_ptr;
    logic [c_BW-1:0]    r_beat_cnt;
    logic [c_GW-1:0]    r_grant_id;

    state_t             w_state_nxt;
    logic [c_GW-1:0]    w_rr_ptr_nxt;
    logic [c_BW-1:0]    w_beat_cnt_nxt;
    logic [c_GW-1:0]    w_grant_id_nxt;

    logic               w_any_valid;
    logic [c_GW-1:0]    w_sel_id;
    logic               w_g_valid;
    logic [WIDTH-1:0]   w_g_data;
    logic [NUM_REQ-1:0] w_g_onehot;
    logic               w_in_burst;
    logic               w_beat;
    logic [c_GW-1:0]    w_after_grant;

    // ------------------------------------------------------------------------
    // Round-robin scan: walk offsets from the highest down so that the
    // smallest offset from r_rr_ptr with a valid request wins.
    // ------------------------------------------------------------------------
    always_comb begin
        w_any_valid = 1'b0;
        w_sel_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_any_valid = 1'b1;
                w_sel_id    = c_GW'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Granted-requester mux. A compare-per-index mux keeps the part-select
    // bounded even when NUM_REQ is not a power of two.
    // ------------------------------------------------------------------------
    always_comb begin
        w_g_valid  = 1'b0;
        w_g_data   = '0;
        w_g_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == c_GW'(i)) begin
                w_g_valid     = req_valid[i];
                w_g_data      = req_data[i*WIDTH +: WIDTH];
                w_g_onehot[i] = 1'b1;
            end
        end
    end

    assign w_in_burst    = (r_state == ST_BURST);
    // fifo_full gates every beat, so wr_en can never coincide with full.
    assign w_beat        = w_in_burst && w_g_valid && !fifo_full;
    assign w_after_grant = (r_grant_id == c_GW'(NUM_REQ - 1)) ? '0
                                                              : r_grant_id + 1'b1;

    assign req_ready     = (w_in_burst && !fifo_full) ? w_g_onehot : '0;
    assign fifo_wr_en    = w_beat;
    assign fifo_data_in  = w_in_burst ? w_g_data : '0;
    assign grant_valid   = w_in_burst;
    assign grant_id      = r_grant_id;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_grant_id_nxt = r_grant_id;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_state_nxt    = ST_BURST;
                    w_grant_id_nxt = w_sel_id;
                    w_beat_cnt_nxt = '0;
                end
            end
            ST_BURST: begin
                if (!w_g_valid) begin
                    // Requester withdrew: end the burst without a beat.
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = w_after_grant;
                end else if (w_beat) begin
                    if (r_beat_cnt == c_LAST) begin
                        w_state_nxt  = ST_IDLE;
                        w_rr_ptr_nxt = w_after_grant;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
                // Valid but FIFO full: hold grant and count unchanged.
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_grant_id <= w_grant_id_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_async_fifo_wr_arbiter
//  Purpose  : Self-checking bench for async_fifo_wr_arbiter (4 requesters,
//             8-bit data, bursts of up to 4 beats). Per-requester scoreboards
//             hold the expected write data; completed grants are logged as
//             episodes (requester, beats, idle gap) for directed checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int GW        = 2;

    logic                     wr_clk = 1'b0;
    logic                     wr_rst = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full = 1'b0;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_data_in;
    logic                     grant_valid;
    logic [GW-1:0]            grant_id;

    always #5 wr_clk = ~wr_clk;

    async_fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Source queues (what each requester still has to send) and scoreboards
    // (what the FIFO must still receive from each requester).
    logic [WIDTH-1:0] src_q [NUM_REQ][$];
    logic [WIDTH-1:0] exp_q [NUM_REQ][$];
    int               seq   [NUM_REQ];
    logic [NUM_REQ-1:0] en_v   = '0;
    logic               full_v = 1'b0;

    typedef struct {
        int gid;
        int beats;
        int gap;
    } ep_t;
    ep_t eps[$];
    bit  in_grant  = 1'b0;
    int  cur_gid   = 0;
    int  cur_beats = 0;
    int  cur_gap   = 0;
    int  idle_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int r, input int n);
        logic [WIDTH-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = WIDTH'(r * 64 + (seq[r] % 64));
            seq[r]++;
            src_q[r].push_back(d);
            exp_q[r].push_back(d);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = en_v[i] && (src_q[i].size() > 0);
            req_data[i*WIDTH +: WIDTH] = req_valid[i] ? src_q[i][0] : '0;
        end
        fifo_full = full_v;
    endtask

    // Inputs are stable here until the next posedge, so what is sampled is
    // exactly what that edge commits.
    task automatic sample();
        logic [NUM_REQ-1:0] exp_ready;
        logic               exp_wr;
        logic [WIDTH-1:0]   d;
        exp_ready = (grant_valid && !fifo_full) ? (NUM_REQ'(1) << grant_id) : '0;
        exp_wr    = grant_valid && !fifo_full && req_valid[grant_id];
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        check("wr_en_while_full", 32'(fifo_wr_en && fifo_full), 32'(0));
        if (!grant_valid)
            check("data_idle", 32'(fifo_data_in), 32'(0));
        if (fifo_wr_en) begin
            if (exp_q[grant_id].size() > 0) begin
                d = exp_q[grant_id].pop_front();
                check($sformatf("data_req%0d", grant_id), 32'(fifo_data_in), 32'(d));
            end else begin
                check("spurious_beat", 32'(fifo_wr_en), 32'(0));
            end
        end
        if (grant_valid) begin
            if (!in_grant) begin
                in_grant  = 1'b1;
                cur_gid   = int'(grant_id);
                cur_beats = 0;
                cur_gap   = idle_cnt;
            end else begin
                check("grant_id_stable", 32'(grant_id), 32'(cur_gid));
            end
            if (fifo_wr_en) cur_beats++;
            check("burst_len_over", 32'(cur_beats > MAX_BURST), 32'(0));
        end else begin
            if (in_grant) begin
                eps.push_back(ep_t'{cur_gid, cur_beats, cur_gap});
                in_grant = 1'b0;
                idle_cnt = 0;
            end
            idle_cnt++;
        end
        for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i] && req_ready[i] && src_q[i].size() > 0)
                void'(src_q[i].pop_front());
    endtask

    task automatic tick();
        @(negedge wr_clk);
        drive_inputs();
        #1;
        sample();
    endtask

    task automatic clear_tracker();
        in_grant  = 1'b0;
        cur_beats = 0;
        idle_cnt  = 0;
        eps.delete();
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        wr_rst = 1'b0;
        en_v   = '0;
        full_v = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        drive_inputs();
        repeat (2) @(negedge wr_clk);
        wr_rst = 1'b1;
        clear_tracker();
    endtask

    function automatic bit pending();
        bit p;
        p = in_grant;
        for (int i = 0; i < NUM_REQ; i++)
            if (src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic run_until_idle(input string tag, input int bound);
        int c;
        c = 0;
        while (pending() && c < bound) begin
            tick();
            c++;
        end
        check({tag, "_timeout"}, 32'(c >= bound), 32'(0));
    endtask

    task automatic check_ep(input string tag, input int k, input int gid, input int beats,
                            input bit chk_gap, input int gap);
        if (k < eps.size()) begin
            check($sformatf("%s_ep%0d_gid", tag, k), 32'(eps[k].gid), 32'(gid));
            check($sformatf("%s_ep%0d_beats", tag, k), 32'(eps[k].beats), 32'(beats));
            if (chk_gap)
                check($sformatf("%s_ep%0d_gap", tag, k), 32'(eps[k].gap), 32'(gap));
        end else begin
            check($sformatf("%s_ep%0d_missing", tag, k), 32'(eps.size()), 32'(k + 1));
        end
    endtask

    task automatic wait_beats(input string tag, input int n);
        int c;
        c = 0;
        while (!(in_grant && cur_beats == n) && c < 40) begin
            tick();
            c++;
        end
        check({tag, "_wait_timeout"}, 32'(c >= 40), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) seq[i] = 0;

        // ---------------- Reset state, asserted before any clock edge -------
        #2 wr_rst = 1'b0;
        #1;
        check("rst_grant_valid", 32'(grant_valid), 32'(0));
        check("rst_wr_en", 32'(fifo_wr_en), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_data", 32'(fifo_data_in), 32'(0));
        check("rst_grant_id", 32'(grant_id), 32'(0));
        repeat (2) @(negedge wr_clk);
        wr_rst = 1'b1;

        // ---------------- Single requester: 10 beats -> 4,4,2 ---------------
        do_reset();
        en_v = 4'b0001;
        load(0, 10);
        run_until_idle("t1", 200);
        check("t1_ep_count", 32'(eps.size()), 32'(3));
        check_ep("t1", 0, 0, 4, 1'b0, 0);
        check_ep("t1", 1, 0, 4, 1'b1, 1);
        check_ep("t1", 2, 0, 2, 1'b1, 1);

        // ---------------- All requesters valid: 0,1,2,3,0,1,2,3 -------------
        do_reset();
        en_v = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) load(i, 8);
        run_until_idle("t2", 400);
        check("t2_ep_count", 32'(eps.size()), 32'(8));
        for (int k = 0; k < 8; k++)
            check_ep("t2", k, k % NUM_REQ, MAX_BURST, k > 0, 1);

        // ---------------- FIFO full mid-burst for 5 cycles ------------------
        do_reset();
        en_v = 4'b0010;
        load(1, 4);
        wait_beats("t3", 2);
        full_v = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_full_ready", 32'(req_ready), 32'(0));
            check("t3_full_wr_en", 32'(fifo_wr_en), 32'(0));
            check("t3_full_grant_valid", 32'(grant_valid), 32'(1));
            check("t3_full_grant_id", 32'(grant_id), 32'(1));
        end
        full_v = 1'b0;
        run_until_idle("t3", 100);
        check("t3_ep_count", 32'(eps.size()), 32'(1));
        check_ep("t3", 0, 1, 4, 1'b0, 0);

        // ---------------- req2 drops after one beat, req3 waiting -----------
        do_reset();
        en_v = 4'b1100;
        load(2, 1);
        load(3, 2);
        run_until_idle("t4", 100);
        check("t4_ep_count", 32'(eps.size()), 32'(2));
        check_ep("t4", 0, 2, 1, 1'b0, 0);
        check_ep("t4", 1, 3, 2, 1'b1, 1);

        // ---------------- Reset mid-burst with beat_cnt=2 -------------------
        do_reset();
        en_v = 4'b1010;
        load(1, 4);
        load(3, 4);
        wait_beats("t5", 2);
        @(negedge wr_clk);
        wr_rst = 1'b0;
        #1;
        check("t5_rst_grant_valid", 32'(grant_valid), 32'(0));
        check("t5_rst_wr_en", 32'(fifo_wr_en), 32'(0));
        check("t5_rst_req_ready", 32'(req_ready), 32'(0));
        check("t5_rst_data", 32'(fifo_data_in), 32'(0));
        check("t5_rst_grant_id", 32'(grant_id), 32'(0));
        repeat (2) @(negedge wr_clk);
        wr_rst = 1'b1;
        clear_tracker();
        run_until_idle("t5", 100);
        check("t5_ep_count", 32'(eps.size()), 32'(2));
        check_ep("t5", 0, 1, 2, 1'b0, 0);
        check_ep("t5", 1, 3, 4, 1'b1, 1);

        // ---------------- Random valid/full traffic -------------------------
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_q[i].size() < 3) load(i, 4);
                en_v[i] = ($urandom_range(0, 9) < 8);
            end
            full_v = ($urandom_range(0, 3) == 0);
            tick();
            if (eps.size() > 64) eps.delete();
        end
        en_v   = 4'b1111;
        full_v = 1'b0;
        run_until_idle("t6_drain", 2000);
        for (int i = 0; i < NUM_REQ; i++)
            check($sformatf("t6_left_req%0d", i), 32'(exp_q[i].size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
